// File: rtl/or1200_sstk_ctrl_pkg.sv
// Shared constants for the OR1200 return-address shadow stack.
// FSM codes are kept as plain 2-bit constants so existing decode logic can compare against them.
package or1200_sstk_ctrl_pkg;

  localparam logic [1:0] OR1200_SSTK_IDLE  = 2'd0;
  localparam logic [1:0] OR1200_SSTK_SPILL = 2'd1;
  localparam logic [1:0] OR1200_SSTK_FILL  = 2'd2;

  localparam int unsigned OR1200_SSTK_AW  = 3;
  localparam int unsigned OR1200_SSTK_MCW = 16;

  // Byte address of spill slot idx: base + idx*4, wrapping at 32 bits.
  function automatic logic [31:0] sstk_slot_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/or1200_sstk_buf.sv
// On-chip return-address buffer: DEPTH x 32 flops, one write port,
// two asynchronous read ports (top-of-stack and oldest entry).
module or1200_sstk_buf
  import or1200_sstk_ctrl_pkg::*;
#(
  parameter int unsigned AW = OR1200_SSTK_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] top_addr_i,
  output logic [31:0]   top_data_o,
  input  logic [AW-1:0] tail_addr_i,
  output logic [31:0]   tail_data_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign top_data_o  = mem_q[top_addr_i];
  assign tail_data_o = mem_q[tail_addr_i];

endmodule

// File: rtl/or1200_sstk_ctrl.sv
// Shadow-stack controller: circular buffer of return addresses, spilling the
// oldest entry to memory when full and refilling from memory when empty.
module or1200_sstk_ctrl
  import or1200_sstk_ctrl_pkg::*;
#(
  parameter int unsigned AW  = OR1200_SSTK_AW,
  parameter int unsigned MCW = OR1200_SSTK_MCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [31:0]    spill_base,
  input  logic           ex_freeze,
  input  logic           call_valid,
  input  logic [31:0]    call_ra,
  input  logic           ret_valid,
  input  logic [31:0]    ret_target,
  output logic           stall_req,
  output logic           mismatch,
  output logic [31:0]    mis_exp,
  output logic [31:0]    mis_act,
  output logic           overflow,
  output logic           underflow,
  output logic           proto_err,
  output logic           mem_req,
  output logic           mem_we,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wdata,
  input  logic [31:0]    mem_rdata,
  input  logic           mem_ack,
  output logic [AW:0]    count,
  output logic [MCW-1:0] mem_cnt
);

  localparam logic [AW:0]    FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW-1:0]  PTR_ONE  = 1;
  localparam logic [MCW-1:0] MCNT_ONE = 1;

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [AW:0]    count_q, count_d;
  logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
  logic           mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic           underflow_q, underflow_d, proto_err_q, proto_err_d;
  logic [31:0]    mis_exp_q, mis_exp_d, mis_act_q, mis_act_d;

  logic           buf_we;
  logic [AW-1:0]  buf_waddr;
  logic [31:0]    buf_wdata, top_rdata, tail_rdata;
  logic [MCW-1:0] slot_idx;

  logic full, empty, mem_full, mem_empty, busy, need_spill, need_fill, accept_ok;

  or1200_sstk_buf #(.AW(AW)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .we_i        (buf_we),
    .waddr_i     (buf_waddr),
    .wdata_i     (buf_wdata),
    .top_addr_i  (head_q - PTR_ONE),
    .top_data_o  (top_rdata),
    .tail_addr_i (tail_q),
    .tail_data_o (tail_rdata)
  );

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign mem_full   = (mem_cnt_q == '1);
  assign mem_empty  = (mem_cnt_q == '0);
  assign busy       = (state_q != OR1200_SSTK_IDLE);
  assign need_spill = call_valid && !ret_valid && full && !mem_full;
  assign need_fill  = ret_valid && !call_valid && empty && !mem_empty;
  // Stall is raised as soon as a blocked event is presented, regardless of ex_freeze.
  assign stall_req  = enable && (busy || need_spill || need_fill);
  assign accept_ok  = enable && !ex_freeze && !stall_req;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_cnt_d   = mem_cnt_q;
    mismatch_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    proto_err_d = 1'b0;
    mis_exp_d   = mis_exp_q;
    mis_act_d   = mis_act_q;
    buf_we      = 1'b0;
    buf_waddr   = head_q;
    buf_wdata   = call_ra;
    case (state_q)
      OR1200_SSTK_IDLE: begin
        if (accept_ok) begin
          if (call_valid && ret_valid) begin
            proto_err_d = 1'b1;
          end else if (call_valid) begin
            if (!full) begin
              buf_we  = 1'b1;
              head_d  = head_q + PTR_ONE;
              count_d = count_q + CNT_ONE;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (ret_valid) begin
            if (!empty) begin
              head_d  = head_q - PTR_ONE;
              count_d = count_q - CNT_ONE;
              if (top_rdata != ret_target) begin
                mismatch_d = 1'b1;
                mis_exp_d  = top_rdata;
                mis_act_d  = ret_target;
              end
            end else begin
              underflow_d = 1'b1;
            end
          end
        end else if (stall_req) begin
          state_d = need_spill ? OR1200_SSTK_SPILL : OR1200_SSTK_FILL;
        end
      end
      OR1200_SSTK_SPILL: begin
        if (mem_ack) begin
          tail_d    = tail_q + PTR_ONE;
          count_d   = count_q - CNT_ONE;
          mem_cnt_d = mem_cnt_q + MCNT_ONE;
          state_d   = OR1200_SSTK_IDLE;
        end
      end
      OR1200_SSTK_FILL: begin
        if (mem_ack) begin
          buf_we    = 1'b1;
          buf_waddr = tail_q - PTR_ONE;
          buf_wdata = mem_rdata;
          tail_d    = tail_q - PTR_ONE;
          count_d   = count_q + CNT_ONE;
          mem_cnt_d = mem_cnt_q - MCNT_ONE;
          state_d   = OR1200_SSTK_IDLE;
        end
      end
      default: state_d = OR1200_SSTK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OR1200_SSTK_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_cnt_q   <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
      mis_exp_q   <= '0;
      mis_act_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_cnt_q   <= mem_cnt_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      proto_err_q <= proto_err_d;
      mis_exp_q   <= mis_exp_d;
      mis_act_q   <= mis_act_d;
    end
  end

  // Fill reads the most recently spilled slot, spill writes the next free one.
  assign slot_idx  = (state_q == OR1200_SSTK_FILL) ? (mem_cnt_q - MCNT_ONE) : mem_cnt_q;
  assign mem_req   = busy;
  assign mem_we    = (state_q == OR1200_SSTK_SPILL);
  assign mem_addr  = busy ? sstk_slot_addr(spill_base, 32'(slot_idx)) : '0;
  assign mem_wdata = (state_q == OR1200_SSTK_SPILL) ? tail_rdata : '0;

  assign mismatch  = mismatch_q;
  assign mis_exp   = mis_exp_q;
  assign mis_act   = mis_act_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign proto_err = proto_err_q;
  assign count     = count_q;
  assign mem_cnt   = mem_cnt_q;

endmodule

// File: tb/tb_or1200_sstk_ctrl.sv
// Directed bench for or1200_sstk_ctrl with a scoreboard of expected memory transactions.
module tb_or1200_sstk_ctrl;

  localparam int unsigned AW  = 2;
  localparam int unsigned MCW = 2;
  localparam logic [31:0] BASE = 32'h0000_8000;

  logic           clk = 1'b0;
  logic           rst, enable, ex_freeze, call_valid, ret_valid, mem_ack;
  logic [31:0]    spill_base, call_ra, ret_target, mem_rdata;
  logic           stall_req, mismatch, overflow, underflow, proto_err, mem_req, mem_we;
  logic [31:0]    mis_exp, mis_act, mem_addr, mem_wdata;
  logic [AW:0]    count;
  logic [MCW-1:0] mem_cnt;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] v [8];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  or1200_sstk_ctrl #(.AW(AW), .MCW(MCW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .spill_base(spill_base), .ex_freeze(ex_freeze),
    .call_valid(call_valid), .call_ra(call_ra), .ret_valid(ret_valid), .ret_target(ret_target),
    .stall_req(stall_req), .mismatch(mismatch), .mis_exp(mis_exp), .mis_act(mis_act),
    .overflow(overflow), .underflow(underflow), .proto_err(proto_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .count(count), .mem_cnt(mem_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Answer the outstanding memory request after lat extra cycles, checking it against the scoreboard.
  task automatic service(input int lat);
    txn_t        e;
    logic [31:0] a0, w0, we0;
    e = '0;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL sb_underrun observed=0 expected=nonzero");
    end
    if (sb.size() != 0) e = sb.pop_front();
    chk("mem_we", 32'(mem_we), 32'(e.we));
    chk("mem_addr", mem_addr, e.addr);
    if (e.we) chk("mem_wdata", mem_wdata, e.data);
    a0 = mem_addr; w0 = mem_wdata; we0 = 32'(mem_we);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      chk("hold", {28'b0, mem_req, stall_req, mem_addr == a0, mem_wdata == w0}, 32'hF);
    end
    mem_ack = 1'b1;
    if (we0 != 0) mem_model[a0] = w0;
    else mem_rdata = mem_model.exists(a0) ? mem_model[a0] : 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    #1;
  endtask

  // Present one event, service any spill/fill it triggers, return just after the accepting edge.
  task automatic run_event(input logic c, input logic r, input logic [31:0] ra,
                           input logic [31:0] tgt, input logic exp_stall, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    call_valid = c; ret_valid = r; call_ra = ra; ret_target = tgt;
    #1;
    chk("stall_first", 32'(stall_req), 32'(exp_stall));
    while (stall_req && guard < 40) begin
      if (mem_req) service(lat);
      else begin
        @(negedge clk); #1;
      end
      guard++;
    end
    checks++;
    assert (guard < 40) else begin
      failures++;
      $error("FAIL stall_timeout observed=%0d expected=<40", guard);
    end
    @(posedge clk); #1;
    call_valid = 1'b0; ret_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1; enable = 1'b0; spill_base = BASE; ex_freeze = 1'b0;
    call_valid = 1'b0; ret_valid = 1'b0; call_ra = '0; ret_target = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) v[i] = 32'h5000 + 32'(i) * 32'h10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {23'b0, stall_req, mismatch, overflow, underflow, proto_err, mem_req, mem_we, 2'b0},
        32'h0);
    chk("rst_mis_exp", mis_exp, 32'h0);
    chk("rst_mis_act", mis_act, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_mem_cnt", 32'(mem_cnt), 32'h0);
    rst = 1'b0; enable = 1'b1;

    // Balanced calls
    run_event(1, 0, 32'h100, 0, 0, 0);
    run_event(1, 0, 32'h200, 0, 0, 0);
    chk("bal_count2", 32'(count), 32'd2);
    run_event(0, 1, 0, 32'h200, 0, 0);
    chk("bal_mis_a", 32'(mismatch), 32'h0);
    run_event(0, 1, 0, 32'h100, 0, 0);
    chk("bal_mis_b", 32'(mismatch), 32'h0);
    chk("bal_count0", 32'(count), 32'h0);

    // Corrupted return
    run_event(1, 0, 32'h1000, 0, 0, 0);
    run_event(0, 1, 0, 32'h1004, 0, 0);
    chk("cor_mis", 32'(mismatch), 32'h1);
    chk("cor_exp", mis_exp, 32'h1000);
    chk("cor_act", mis_act, 32'h1004);
    chk("cor_count", 32'(count), 32'h0);
    @(posedge clk); #1;
    chk("cor_pulse_end", 32'(mismatch), 32'h0);
    chk("cor_exp_held", mis_exp, 32'h1000);

    // Underflow and protocol error
    run_event(0, 1, 0, 32'h44, 0, 0);
    chk("udf_pulse", 32'(underflow), 32'h1);
    chk("udf_cnts", {27'b0, count, mem_cnt}, 32'h0);
    run_event(1, 0, 32'h300, 0, 0, 0);
    run_event(1, 1, 32'h400, 32'h300, 0, 0);
    chk("proto_pulse", 32'(proto_err), 32'h1);
    chk("proto_count", 32'(count), 32'h1);
    run_event(0, 1, 0, 32'h300, 0, 0);
    chk("proto_pop_mis", 32'(mismatch), 32'h0);

    // Spill and fill, A..E
    for (int i = 0; i < 4; i++) run_event(1, 0, 32'hA0 + 32'(i) * 32'h10, 0, 0, 0);
    sb.push_back('{we: 1'b1, addr: BASE, data: 32'hA0});
    run_event(1, 0, 32'hE0, 0, 1, 0);
    chk("spill_count", 32'(count), 32'd4);
    chk("spill_mem_cnt", 32'(mem_cnt), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      run_event(0, 1, 0, 32'hA0 + 32'(i) * 32'h10, 0, 0);
      chk("pop_mis", 32'(mismatch), 32'h0);
    end
    chk("pre_fill_cnts", {27'b0, count, mem_cnt}, 32'h1);
    sb.push_back('{we: 1'b0, addr: BASE, data: 32'h0});
    run_event(0, 1, 0, 32'hA0, 1, 0);
    chk("fill_mis", 32'(mismatch), 32'h0);
    chk("fill_cnts", {27'b0, count, mem_cnt}, 32'h0);

    // Slow memory, memory full, overflow, then drain with fills
    for (int i = 0; i < 4; i++) run_event(1, 0, v[i], 0, 0, 0);
    for (int i = 4; i < 7; i++) begin
      sb.push_back('{we: 1'b1, addr: BASE + 32'(i - 4) * 32'd4, data: v[i-4]});
      run_event(1, 0, v[i], 0, 1, (i == 4) ? 7 : 1);
    end
    chk("mfull_cnt", 32'(count), 32'd4);
    chk("mfull_mem_cnt", 32'(mem_cnt), 32'd3);
    run_event(1, 0, v[7], 0, 0, 0);
    chk("ovf_pulse", 32'(overflow), 32'h1);
    chk("ovf_cnts", {27'b0, count, mem_cnt}, {27'b0, 3'd4, 2'd3});
    for (int i = 6; i >= 3; i--) begin
      run_event(0, 1, 0, v[i], 0, 0);
      chk("drain_mis", 32'(mismatch), 32'h0);
    end
    for (int k = 2; k >= 0; k--) begin
      sb.push_back('{we: 1'b0, addr: BASE + 32'(k) * 32'd4, data: 32'h0});
      run_event(0, 1, 0, v[k], 1, 2);
      chk("refill_mis", 32'(mismatch), 32'h0);
    end
    chk("drain_cnts", {27'b0, count, mem_cnt}, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    // ex_freeze blocks acceptance
    @(negedge clk);
    ex_freeze = 1'b1; call_valid = 1'b1; call_ra = 32'h77;
    #1;
    chk("frz_stall", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("frz_count", 32'(count), 32'h0);
    @(negedge clk);
    call_valid = 1'b0; ex_freeze = 1'b0;

    // Reset while a spill is outstanding
    for (int i = 0; i < 4; i++) run_event(1, 0, 32'h900 + 32'(i), 0, 0, 0);
    @(negedge clk);
    call_valid = 1'b1; call_ra = 32'h999;
    g = 0;
    do begin
      @(negedge clk); #1;
      g++;
    end while (!mem_req && g < 5);
    chk("rst_mid_req_pre", 32'(mem_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_cnts", {27'b0, count, mem_cnt}, 32'h0);
    chk("rst_mid_stall", 32'(stall_req), 32'h0);
    call_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
